// File: rtl/po_fifo_pkg.sv
// Shared defaults and width helpers for the parallel-word FIFO.
// Build option: PO_FIFO_PARITY_EN adds a stored parity bit per word.
`timescale 1ns/1ps
package po_fifo_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = PTR_W_DEF + 1;

  // Pointer width for a power-of-two depth; count needs one bit more to hold DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/po_fifo_ram.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
// Build option PO_FIFO_PARITY_EN only changes DW as seen from the top.
`timescale 1ns/1ps
module po_fifo_ram
  import po_fifo_pkg::*;
#(
  parameter int DW    = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = PTR_W_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/po_word_fifo.sv
// Show-ahead word FIFO behind a SIPO stage, with sticky overflow on dropped words.
// Build option PO_FIFO_PARITY_EN: adds out_parity (XOR of the word, captured at push).
`timescale 1ns/1ps
module po_word_fifo
  import po_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_word,
  input  logic                         in_load,
  output logic [WIDTH-1:0]             out_word,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
`ifdef PO_FIFO_PARITY_EN
  , output logic                       out_parity
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef PO_FIFO_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;
  logic [SW-1:0]    wdata, rdata;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push      = in_load & (~full | pop);

`ifdef PO_FIFO_PARITY_EN
  assign wdata      = {^in_word, in_word};
  assign out_parity = empty ? 1'b0 : rdata[WIDTH];
`else
  assign wdata = in_word;
`endif

  // Storage is never cleared, so mask the read port while nothing is stored.
  assign out_word = empty ? '0 : rdata[WIDTH-1:0];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_load & full & ~pop);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  po_fifo_ram #(
    .DW    (SW),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

endmodule

// File: doc/po_word_fifo.md
PO_WORD_FIFO -- requirements
Module: po_word_fifo

Interface
REQ-001 Parameter: WIDTH, 8, bits per parallel word.
REQ-002 Parameter: DEPTH, 4, number of word entries; SHALL be a power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_word  input  WIDTH  parallel word from the upstream SIPO stage.
REQ-006 Port: in_load  input  1  write strobe; one word offered per cycle while high.
REQ-007 Port: out_word  output  WIDTH  head-of-queue word, show-ahead.
REQ-008 Port: out_valid  output  1  high when out_word holds a stored word.
REQ-009 Port: out_ready  input  1  consumer accepts out_word this cycle.
REQ-010 Port: full  output  1  count equals DEPTH.
REQ-011 Port: empty  output  1  count equals 0.
REQ-012 Port: count  output  $clog2(DEPTH)+1  number of stored words.
REQ-013 Port: overflow  output  1  sticky flag: a word was dropped.

Function
REQ-014 Pop SHALL occur when out_valid and out_ready are both high; the read pointer advances modulo DEPTH.
REQ-015 Push SHALL occur when in_load is high and either full is low or a pop occurs in the same cycle; in_word is stored at the write pointer, which advances modulo DEPTH.
REQ-016 A word pushed at edge N SHALL appear on out_word, with out_valid high, from edge N onward when the FIFO was empty (one-cycle latency from in_load sample to out_valid).
REQ-017 out_valid SHALL equal not empty; out_word SHALL be don't-care while empty.
REQ-018 count SHALL change by +1 on push only, by -1 on pop only, and be unchanged on simultaneous push and pop.
REQ-019 When empty, push with out_ready high SHALL store the word and SHALL NOT pop.
REQ-020 When full, in_load with a simultaneous pop SHALL be accepted; count stays DEPTH.
REQ-021 When full, in_load without a pop SHALL drop in_word, leave storage unchanged, and set overflow.
REQ-022 Once set, overflow SHALL stay high until reset.
REQ-023 Stored word order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-024 On reset low, the block SHALL immediately clear the read pointer, the write pointer, count, and overflow, independent of clk.
REQ-025 During reset, outputs SHALL be empty=1, full=0, out_valid=0, count=0, overflow=0, out_word=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; storage contents need not be cleared.

Configuration
REQ-027 Macro PO_FIFO_PARITY_EN, when defined, SHALL add output out_parity (1 bit), equal to the even parity (XOR) of the word computed at push, stored alongside it, and presented with out_word.
REQ-028 When PO_FIFO_PARITY_EN is defined, out_parity SHALL be 0 during reset and while empty.
REQ-029 When PO_FIFO_PARITY_EN is undefined, the out_parity port SHALL be absent and storage SHALL be WIDTH bits wide.

Structure
REQ-030 Package po_fifo_pkg SHALL hold the WIDTH and DEPTH defaults and the pointer/count width constants.
REQ-031 Storage SHALL be a sub-module, po_fifo_ram: one synchronous write port and one asynchronous read port, with no reset.

Verification
REQ-032 Reset: hold reset=0 for 10 ps, then release -> empty=1, count=0, overflow=0, out_valid=0.
REQ-033 Push 8'h5A, 8'hC3, 8'h01 with out_ready=0, then hold out_ready=1 -> out_word reads 5A, C3, 01 on consecutive cycles; count goes 3,2,1,0.
REQ-034 Push 5 words 8'h10..8'h14 with out_ready=0 and DEPTH=4 -> full=1 after the 4th; overflow=1 after the 5th; drain yields 10, 11, 12, 13 only.
REQ-035 When full, in_load=1 with in_word 8'hAA and out_ready=1 in the same cycle -> count stays 4, overflow stays 0, and AA is last out.
REQ-036 Stream 10 words with in_load and out_ready both held high -> output order is preserved across wrap-around and count never exceeds 1.
REQ-037 With PO_FIFO_PARITY_EN defined, push 8'h07 then 8'h03 -> out_parity is 1 then 0; assert reset with 2 words stored -> empty=1 immediately.
